// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding, the default frame start byte and
// the widths of the frame fields.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTE_W         = 8;
    localparam int         WORD_W         = 32;
    localparam int         COUNT_W        = 8;
    localparam int         BYTES_PER_WORD = 4;

    // Byte address of word idx relative to a base; idx * 4 never exceeds
    // 10 bits, so the addition cannot wrap for any sane base.
    function automatic logic [WORD_W-1:0] word_addr(
        input logic [WORD_W-1:0]  base,
        input logic [COUNT_W-1:0] idx
    );
        return base + {{(WORD_W-COUNT_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// The first three bytes of a word are held in a shift register; the
// fourth byte is combined combinationally so the caller can latch the
// complete word on the same edge that accepts its last byte.
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    localparam int POS_W = $clog2(BYTES_PER_WORD);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BYTES_PER_WORD - 1);

    logic [POS_W-1:0]              byte_pos;
    logic [(WORD_W-BYTE_W)-1:0]    shift_q;

    // Track the byte position inside the word and shift in leading bytes.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_pos <= '0;
            shift_q  <= '0;
        end else if (byte_valid) begin
            byte_pos <= byte_pos + 1'b1;
            shift_q  <= {shift_q[(WORD_W-2*BYTE_W)-1:0], byte_data};
        end
    end

    assign word_done = byte_valid && (byte_pos == LAST_POS);
    assign word      = {shift_q, byte_data};

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction loader in front of the single-cycle CPU.
// Parses frames of MAGIC, word count N, 4N big-endian data bytes and an
// XOR checksum byte, writes each completed word into the CPU instruction
// memory and releases the CPU from reset only after a frame checks out.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64,
    parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT,
    parameter int          TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam int                  TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [COUNT_W-1:0]  MAX_N    = COUNT_W'(MAX_WORDS);

    loader_state_e       state;
    loader_state_e       state_nxt;

    logic                rx_ready_q;
    logic                accept;
    logic                is_magic;
    logic                in_frame;
    logic                frame_start;
    logic                timeout_hit;
    logic                pack_valid;
    logic                word_done;
    logic                last_word;
    logic [WORD_W-1:0]   packed_word;
    logic [COUNT_W-1:0]  word_count;
    logic [COUNT_W-1:0]  word_idx;
    logic [BYTE_W-1:0]   csum;
    logic [TMR_W-1:0]    idle_cnt;

    assign rx_ready    = rx_ready_q;
    assign accept      = rx_valid && rx_ready_q;
    assign is_magic    = (rx_data == MAGIC);
    assign in_frame    = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
    assign timeout_hit = in_frame && !accept && (idle_cnt == TMR_LAST);
    assign pack_valid  = accept && (state == ST_DATA);
    assign last_word   = (word_idx == (word_count - 1'b1));

    word_packer u_word_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (frame_start),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word_done  (word_done),
        .word       (packed_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a MAGIC byte restarts only from IDLE/DONE/ERROR,
    // inside DATA and CHECK it is ordinary payload.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && is_magic) begin
                    state_nxt   = ST_COUNT;
                    frame_start = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if ((rx_data == '0) || (rx_data > MAX_N)) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else if (timeout_hit) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (word_done && last_word) begin
                        state_nxt = ST_CHECK;
                    end
                end else if (timeout_hit) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_nxt = (rx_data == csum) ? ST_DONE : ST_ERROR;
                end else if (timeout_hit) begin
                    state_nxt = ST_ERROR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: word count, index of the word being assembled,
    // running XOR of all data bytes.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            word_count <= '0;
            word_idx   <= '0;
            csum       <= '0;
        end else begin
            if ((state == ST_COUNT) && accept) begin
                word_count <= rx_data;
            end
            if (word_done) begin
                word_idx <= word_idx + 1'b1;
            end
            if (pack_valid) begin
                csum <= csum ^ rx_data;
            end
        end
    end

    // Idle-cycle counter inside a frame; any accepted byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || accept || !in_frame) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Registered outputs toward the byte source and the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_q                     <= 1'b0;
            initialize                     <= 1'b0;
            instruction_initialize_data    <= '0;
            instruction_initialize_address <= '0;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            error                          <= 1'b0;
        end else begin
            rx_ready_q <= 1'b1;
            initialize <= word_done;
            if (word_done) begin
                instruction_initialize_data    <= packed_word;
                instruction_initialize_address <= word_addr(BASE_ADDR, word_idx);
            end
            cpu_rst <= (state_nxt != ST_DONE);
            done    <= (state_nxt == ST_DONE);
            error   <= (state_nxt == ST_ERROR);
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader sitting directly upstream of the single-cycle `cpu`. It accepts a framed byte stream (e.g. from a UART receiver) and assembles big-endian 32-bit instruction words. It drives the CPU's instruction-memory initialization port (`initialize`, `instruction_initialize_data`, `instruction_initialize_address`) and holds the CPU in reset until a complete, checksum-valid program has been written.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0: byte address of the first instruction word.
- `MAX_WORDS`, 64: largest legal word count per frame, range 1..255.
- `MAGIC`, 8'hA5: frame start byte.
- `TIMEOUT`, 1_000_000: maximum idle cycles between bytes inside a frame.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_valid`  in  1: byte available on `rx_data`.
- `rx_data`  in  8: received byte.
- `rx_ready`  out  1: loader accepts a byte this cycle; a transfer occurs when `rx_valid && rx_ready`.
- `initialize`  out  1: one-cycle write strobe to the CPU instruction memory.
- `instruction_initialize_data`  out  32: word being written.
- `instruction_initialize_address`  out  32: byte address of the word.
- `cpu_rst`  out  1: reset to the CPU, active high.
- `done`  out  1: last frame loaded successfully.
- `error`  out  1: last frame failed (bad count, checksum or timeout).

## Operation
- Frame format: `MAGIC`, count byte N, then 4N data bytes (MSB first per word), then checksum byte.
- The checksum is the XOR of all 4N data bytes.
- States and transitions:
  - IDLE → COUNT on a `MAGIC` byte. Other bytes are dropped.
  - COUNT → DATA if 1 ≤ N ≤ MAX_WORDS; otherwise → ERROR.
  - DATA → CHECK after byte 4N.
  - CHECK → DONE on a checksum match; otherwise → ERROR.
  - DONE → COUNT, and ERROR → COUNT, on a `MAGIC` byte. Other bytes are dropped.
  - COUNT, DATA or CHECK → ERROR on timeout.
- Word write: when the 4th byte of word i is accepted, latch the data, set address = `BASE_ADDR + 4*i`, and pulse `initialize` for one cycle.
  - Address arithmetic is 32-bit; wrap-around is ignored because N ≤ 255.
- `cpu_rst`:
  - Deasserts only while in DONE.
  - Reasserts in the same cycle that a `MAGIC` byte is accepted in DONE, i.e. a reload restarts the CPU.
  - Stays asserted in ERROR.
- `done` is high only in DONE; `error` is high only in ERROR. Both clear when a new `MAGIC` byte is accepted.
- Words already written before an ERROR are not rolled back. The CPU stays in reset until a full valid frame is received.
- `rx_ready` is 1 in every state after reset. The loader never stalls, since at most one byte arrives per cycle and the write takes one registered cycle.
- Timeout counter:
  - Clears on every accepted byte and on entry to COUNT.
  - Counts in COUNT, DATA and CHECK.
  - Reaching `TIMEOUT` triggers ERROR.

## Timing
- Reset values (while `rst`=1 and the cycle after):
  - `initialize`=0, data=0, address=0.
  - `cpu_rst`=1, `done`=0, `error`=0, `rx_ready`=0.
  - State IDLE, all counters 0.
- `rx_ready` rises one cycle after `rst` deasserts.
- Write latency: 4th byte accepted at edge t → `initialize`=1 with valid data/address during cycle t..t+1. It is 0 again after edge t+1.
- Checksum byte accepted at edge t → `done`/`error` and `cpu_rst` update at edge t (registered) and are visible in the following cycle.
- Bad count: the transition to ERROR occurs at the edge accepting the count byte.
- `rst` asserted mid-frame: the frame is abandoned, outputs return to reset values at the next edge, and no partial word is written.
- A `MAGIC` value arriving inside DATA or CHECK is treated as data or checksum, not as a restart.
- `rx_valid` low for a cycle inside a word: the byte position holds; the timeout counter advances.

## Structure
- Shared package `loader_pkg` holds:
  - State enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR).
  - Default `MAGIC`.
  - Frame-field width constants.
- Sub-module `word_packer`: shifts in bytes and reports word complete after 4. It has a synchronous clear, driven on frame start and on `rst`.
- Top level contains: FSM, word index/address counter, XOR checksum register, timeout counter, output registers.

## Test plan
- Frame A5 01 20 08 00 05 2D → one `initialize` pulse, data 32'h20080005, address 0; DONE; `done`=1, `cpu_rst`=0.
- Frame A5 02 + 8 bytes + correct XOR → two pulses at addresses 0 and 4 with `BASE_ADDR`=0. Repeat with `BASE_ADDR`=32'h100 → addresses 0x100 and 0x104.
- Same frame as scenario 1 with checksum 00 → one write occurs, then ERROR; `error`=1, `cpu_rst` stays 1. A following valid frame reaches DONE and clears `error`.
- A5 00, and A5 with N = `MAX_WORDS`+1 → ERROR at the count byte; no `initialize` pulse.
- Run with `TIMEOUT`=16: send A5 02 then 3 data bytes, then silence → ERROR after 16 idle cycles. Also assert `rst` mid-DATA → all outputs at reset values with no stray pulse. Garbage bytes in IDLE are ignored.
